apb_slave_responder: RTL

APB_SLAVE_RESPONDER -- requirements
Module: apb_slave_responder

---
 rtl/apb_slave_pkg.sv | 14 +
 rtl/apb_slave_mem.sv | 35 +++
 rtl/apb_slave_responder.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/apb_slave_pkg.sv
// Shared types and default constants for the APB slave responder.
package apb_slave_pkg;

  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_DEPTH      = 16;
  localparam int WAIT_W         = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

endpackage

// File: rtl/apb_slave_mem.sv
// Word storage for the APB slave: synchronous byte-enabled write, asynchronous read,
// whole array cleared by the asynchronous reset.
module apb_slave_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  localparam int IDX_W     = $clog2(DEPTH),
  localparam int BE_W      = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [BE_W-1:0]       be,
  input  logic [IDX_W-1:0]      raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // NOTE: the array is reset on purpose (cleared storage is part of the contract),
  // which rules out block-RAM mapping; it becomes a bank of resettable flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      for (int b = 0; b < BE_W; b++) begin
        if (be[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/apb_slave_responder.sv
// APB slave with programmable wait states and range/alignment error response.
// Define APB_SLAVE_PSTRB_EN to honour pstrb byte strobes; otherwise writes are full-word.
module apb_slave_responder
  import apb_slave_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH
) (
  input  logic                    pclk,
  input  logic                    preset_n,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  input  logic [WAIT_W-1:0]       wait_cycles,
  output logic                    pready,
  output logic                    pslverr,
  output logic [DATA_WIDTH-1:0]   prdata
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int OFFS  = $clog2(BE_W);
  localparam int IDX_W = $clog2(DEPTH);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  write_q, write_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]       strb_q, strb_d;
  logic                  err_q, err_d;
  logic [WAIT_W-1:0]     cnt_q, cnt_d;
  logic                  pready_d, pslverr_d;
  logic [DATA_WIDTH-1:0] prdata_d;

  logic                  mem_we;
  logic [IDX_W-1:0]      mem_raddr;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic [BE_W-1:0]       mem_be;
  logic                  setup_err;

  function automatic logic addr_err(input logic [ADDR_WIDTH-1:0] a);
    return ((a >> OFFS) >= ADDR_WIDTH'(DEPTH)) || ((a & ADDR_WIDTH'(BE_W - 1)) != '0);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    return IDX_W'(a >> OFFS);
  endfunction

  assign setup_err = addr_err(paddr);
  // A zero-wait read samples storage during setup, before the address is latched.
  assign mem_raddr = (state_q == IDLE) ? word_idx(paddr) : word_idx(addr_q);

`ifdef APB_SLAVE_PSTRB_EN
  assign mem_be = strb_q;
`else
  logic unused_strb;
  assign unused_strb = ^strb_q;
  assign mem_be      = '1;
`endif

  // NOTE: every signal assigned below gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    write_d   = write_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    pready_d  = pready;
    pslverr_d = pslverr;
    prdata_d  = prdata;
    mem_we    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (psel && !penable) begin
          state_d   = ACCESS;
          addr_d    = paddr;
          write_d   = pwrite;
          wdata_d   = pwdata;
          strb_d    = pstrb;
          err_d     = setup_err;
          cnt_d     = wait_cycles;
          pready_d  = (wait_cycles == '0);
          pslverr_d = setup_err && (wait_cycles == '0);
          if ((wait_cycles == '0) && !pwrite) prdata_d = setup_err ? '0 : mem_rdata;
        end
      end
      ACCESS: begin
        if (!psel) begin
          state_d   = IDLE;
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
        end else if (!pready) begin
          cnt_d = cnt_q - WAIT_W'(1);
          if (cnt_q == WAIT_W'(1)) begin
            pready_d  = 1'b1;
            pslverr_d = err_q;
            if (!write_q) prdata_d = err_q ? '0 : mem_rdata;
          end
        end else if (penable) begin
          mem_we    = write_q && !err_q;
          state_d   = IDLE;
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge value of every other register.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      pready  <= 1'b0;
      pslverr <= 1'b0;
      prdata  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      pready  <= pready_d;
      pslverr <= pslverr_d;
      prdata  <= prdata_d;
    end
  end

  apb_slave_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_mem (
    .clk  (pclk),
    .rst_n(preset_n),
    .we   (mem_we),
    .waddr(word_idx(addr_q)),
    .wdata(wdata_q),
    .be   (mem_be),
    .raddr(mem_raddr),
    .rdata(mem_rdata)
  );

endmodule
